// File: rtl/dmem_hex_dump_pkg.sv
// Shared types and constants for the data-memory hex dump engine.
package dump_pkg;

    // Dump sequencer states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        FIN  = 3'd4
    } state_t;

    // ASCII building blocks for lowercase hex text.
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A_OFS = 8'h57;  // 0x57 + 10 = 'a'
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // Eight hex digits plus the trailing newline.
    localparam int CHARS_PER_WORD = 9;
    localparam logic [3:0] LAST_CHAR = 4'(CHARS_PER_WORD - 1);

endpackage

// File: rtl/dmem_hex_dump_if.sv
// Bundle of the dump engine's control, memory-read and byte-stream signals.
interface dmem_hex_dump_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    // Control
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              done;

    // Data memory read port (1-cycle latency)
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;

    // ASCII byte stream
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;

    // The dump engine side.
    modport master (
        input  start, base_addr, word_count, mem_rd_data, byte_ready,
        output busy, done, mem_rd_en, mem_addr, byte_data, byte_valid
    );

    // The controller / memory / byte sink side.
    modport slave (
        output start, base_addr, word_count, mem_rd_data, byte_ready,
        input  busy, done, mem_rd_en, mem_addr, byte_data, byte_valid
    );

endinterface

// File: rtl/dmem_hex_dump_nibble_ascii.sv
// Converts one 4-bit nibble into its lowercase ASCII hex character.
module nibble_ascii
    import dump_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    // Digits map onto '0'..'9', letters onto 'a'..'f'.
    always_comb begin
        ascii = ASCII_0 + {4'd0, nibble};
        if (nibble > 4'd9) begin
            ascii = ASCII_A_OFS + {4'd0, nibble};
        end
    end

endmodule

// File: rtl/dmem_hex_dump.sv
// Data-memory hex dump engine: reads a window of words and streams each one
// as eight lowercase hex characters plus a newline over a valid/ready link.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; counters latched on an accepted start
//   READ  | read strobe issued for the current word address
//   WAIT  | memory data arrives; captured into the word register
//   SEND  | presenting characters 0..8 of the current word
//   FIN   | one-cycle done pulse, then back to IDLE
module dmem_hex_dump
    import dump_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_0,
    dmem_hex_dump_if.master   bus
);

    localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   REMAIN_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     remain_q;
    logic [DATA_W-1:0]   word_q;
    logic [3:0]          idx_q;

    logic                handshake;
    logic                last_char;
    logic [DATA_W-1:0]   word_shifted;
    logic [3:0]          cur_nibble;
    logic [7:0]          cur_ascii;

    assign handshake = (state_q == SEND) && bus.byte_ready;
    assign last_char = (idx_q == LAST_CHAR);

    // Shift the selected nibble to the top so it is always read from one place;
    // at the newline index the shifted value is irrelevant.
    assign word_shifted = word_q << {idx_q[2:0], 2'b00};
    assign cur_nibble   = word_shifted[DATA_W-1 -: 4];

    nibble_ascii u_nibble_ascii (
        .nibble (cur_nibble),
        .ascii  (cur_ascii)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset_0) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; the word-count test in IDLE uses the incoming value
    // because it is being latched on the same edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = (bus.word_count == '0) ? FIN : READ;
                end
            end
            READ: state_d = WAIT;
            WAIT: state_d = SEND;
            SEND: begin
                if (handshake && last_char) begin
                    state_d = (remain_q > REMAIN_ONE) ? READ : FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state and registered datapath only, so byte_ready
    // never reaches byte_valid combinationally.
    always_comb begin
        bus.mem_rd_en  = (state_q == READ);
        bus.mem_addr   = addr_q;
        bus.byte_valid = (state_q == SEND);
        bus.busy       = (state_q != IDLE);
        bus.done       = (state_q == FIN);
        bus.byte_data  = 8'h00;
        if (state_q == SEND) begin
            bus.byte_data = last_char ? ASCII_LF : cur_ascii;
        end
    end

    // Address, remaining-word, word-register and character-index updates.
    always_ff @(posedge clock) begin
        if (reset_0) begin
            addr_q   <= '0;
            remain_q <= '0;
            word_q   <= '0;
            idx_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        addr_q   <= bus.base_addr;
                        remain_q <= bus.word_count;
                    end
                end
                WAIT: begin
                    word_q <= bus.mem_rd_data;
                    idx_q  <= '0;
                end
                SEND: begin
                    if (handshake) begin
                        if (last_char) begin
                            addr_q   <= addr_q + ADDR_ONE;
                            remain_q <= remain_q - REMAIN_ONE;
                            idx_q    <= '0;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_hex_dump.sv
// Randomised scoreboard bench for the data-memory hex dump engine.
module tb_dmem_hex_dump;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_hex_dump_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    dmem_hex_dump #(.ADDR_W(8), .DATA_W(32)) dut (
        .clock   (clk),
        .reset_0 (rst),
        .bus     (bus)
    );

    logic [31:0] mem [0:255];
    logic [7:0]  exp_bytes [$];
    int          exp_addr  [$];
    int          exp_done  [$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    bit          bp_mode     = 1'b0;

    // Data memory with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_extra(string name, logic [31:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
    endfunction

    // Reference: each word becomes its %08h text plus a newline.
    task automatic push_dump(int base, int count);
        for (int w = 0; w < count; w++) begin
            int    a;
            string s;
            a = (base + w) % 256;
            exp_addr.push_back(a);
            s = $sformatf("%08h", mem[a]);
            for (int i = 0; i < 8; i++) exp_bytes.push_back(s[i]);
            exp_bytes.push_back(8'h0A);
        end
    endtask

    // Sink readiness changes just after each rising edge.
    initial begin
        bus.byte_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.byte_ready = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // Byte monitor: ordering, content and hold-while-stalled.
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'h00;
    always @(negedge clk) begin
        if (!rst) begin
            if (pv && !pr) begin
                check("hold_valid", {31'd0, bus.byte_valid}, 32'd1);
                check("hold_data", {24'd0, bus.byte_data}, {24'd0, pd});
            end
            if (bus.byte_valid && bus.byte_ready) begin
                if (exp_bytes.size() == 0) fail_extra("unexpected_byte", {24'd0, bus.byte_data});
                else check("byte", {24'd0, bus.byte_data}, {24'd0, exp_bytes.pop_front()});
            end
        end
        pv <= bus.byte_valid && !rst;
        pr <= bus.byte_ready;
        pd <= bus.byte_data;
    end

    // Read-address monitor.
    always @(negedge clk) begin
        if (!rst && bus.mem_rd_en) begin
            if (exp_addr.size() == 0) fail_extra("unexpected_read", {24'd0, bus.mem_addr});
            else check("rd_addr", {24'd0, bus.mem_addr}, exp_addr.pop_front());
        end
    end

    // Done monitor: timing (when known) and nothing left outstanding.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (exp_done.size() == 0) begin
                fail_extra("unexpected_done", cyc);
            end else begin
                int e;
                e = exp_done.pop_front();
                if (e >= 0) check("done_cycle", cyc, e);
                check("bytes_left_at_done", exp_bytes.size(), 0);
                check("reads_left_at_done", exp_addr.size(), 0);
            end
        end
    end

    // Called at a falling edge; start is taken on the next rising edge (edge 0).
    task automatic launch(int base, int count, bit timed);
        push_dump(base, count);
        exp_done.push_back(timed ? cyc + 11 * count + 1 : -1);
        bus.start      = 1'b1;
        bus.base_addr  = 8'(base);
        bus.word_count = 9'(count);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        check("idle_timeout", {31'd0, bus.busy}, 32'd0);
        check("bytes_left", exp_bytes.size(), 0);
        check("done_left", exp_done.size(), 0);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_rd_en"},  {31'd0, bus.mem_rd_en},  32'd0);
        check({tag, "_addr"},   {24'd0, bus.mem_addr},   32'd0);
        check({tag, "_data"},   {24'd0, bus.byte_data},  32'd0);
        check({tag, "_valid"},  {31'd0, bus.byte_valid}, 32'd0);
        check({tag, "_busy"},   {31'd0, bus.busy},       32'd0);
        check({tag, "_done"},   {31'd0, bus.done},       32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.word_count = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single word.
        mem[16] = 32'h1234abcd;
        launch(16, 1, 1'b1);
        wait_idle();

        // Three words with extreme values, then a back-to-back restart.
        mem[0] = 32'h00000000;
        mem[1] = 32'hffffffff;
        mem[2] = 32'h0000000a;
        launch(0, 3, 1'b1);
        wait_idle();
        launch($urandom_range(0, 255), 2, 1'b1);
        wait_idle();

        // Address wrap-around.
        launch(8'hFE, 3, 1'b1);
        wait_idle();

        // Zero count.
        launch($urandom_range(0, 255), 0, 1'b1);
        wait_idle();

        // Start pulsed during SEND must be ignored.
        launch(8'h30, 2, 1'b1);
        repeat (4) @(negedge clk);
        bus.start      = 1'b1;
        bus.base_addr  = 8'h90;
        bus.word_count = 9'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // Full 256-word window.
        launch($urandom_range(0, 255), 256, 1'b1);
        wait_idle();

        // Backpressure: ready high about 30% of cycles.
        bp_mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            launch($urandom_range(0, 255), $urandom_range(1, 6), 1'b0);
            wait_idle();
        end
        bp_mode = 1'b0;
        repeat (2) @(negedge clk);

        // Reset while the 5th character of word 2 is presented (cycle 18).
        launch(8'h40, 3, 1'b1);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_bytes.delete();
        exp_addr.delete();
        exp_done.delete();
        check_reset_outputs("midreset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        launch(8'h80, 2, 1'b1);
        wait_idle();

        // Random timed dumps.
        for (int k = 0; k < 5; k++) begin
            launch($urandom_range(0, 255), $urandom_range(0, 5), 1'b1);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_hex_dump.md
# dmem_hex_dump

Post-run data-memory dump engine for the 5-stage MIPS pipeline. After the bench or a debug controller pulses `start`, the block walks a window of data memory through a 1-cycle-latency read port. It emits each 32-bit word as 8 lowercase ASCII hex characters followed by a newline (0x0A), producing the same one-word-per-line text format the test flow reads back from `data.txt`. Output is a byte stream under a valid/ready handshake, feeding a UART TX or a bench-side file writer.

## Interface
Parameters:
- `ADDR_W`, 8, word-address width of the data memory port.
- `DATA_W`, 32, memory word width; fixed at 32 (8 hex characters per line).

Ports:
- `clock` in 1 — single clock, all state on the rising edge.
- `reset_0` in 1 — reset is synchronous and active-high.
- `start` in 1 — one-cycle request; sampled only in IDLE.
- `base_addr` in ADDR_W — first word address; latched on accepted `start`.
- `word_count` in ADDR_W+1 — number of words to dump; latched on accepted `start`.
- `mem_rd_en` out 1 — read strobe to data memory.
- `mem_addr` out ADDR_W — read word address.
- `mem_rd_data` in 32 — read data, valid the cycle after `mem_rd_en`.
- `byte_data` out 8 — ASCII output byte.
- `byte_valid` out 1 — `byte_data` is valid.
- `byte_ready` in 1 — sink accepts when `byte_valid && byte_ready`.
- `busy` out 1 — high in every state except IDLE.
- `done` out 1 — one-cycle pulse at the end of a dump.

## Operation
- States: IDLE → READ → WAIT → SEND → (READ | FIN) → IDLE.
- IDLE: `start` latches `base_addr` into the address counter and `word_count` into the remaining counter.
  - Remaining = 0: go to FIN.
  - Otherwise: go to READ.
- READ: `mem_rd_en`=1, `mem_addr` = current address; next state WAIT.
- WAIT: capture `mem_rd_data` into the word register; char index ← 0; go to SEND.
- SEND: `byte_valid`=1.
  - Index 0..7: `byte_data` = ASCII of nibble [31-4i:28-4i]. MS nibble first; 0-9 → 0x30-0x39, a-f → 0x61-0x66.
  - Index 8: `byte_data` = 0x0A.
  - Each handshake advances the index.
  - On the handshake at index 8: address ← address+1 (wraps modulo 2^ADDR_W), remaining ← remaining−1. Go to READ if remaining was >1, else FIN.
- FIN: `done`=1 for exactly one cycle, `busy`=1; next state IDLE.
- `start` is ignored outside IDLE.
- `byte_data` holds stable while `byte_valid && !byte_ready`.
- `byte_ready` is ignored when `byte_valid`=0.
- Reset mid-dump: the next edge forces IDLE, no further bytes, and no `done`.

## Timing
- Reset values: `mem_rd_en`=0, `mem_addr`=0, `byte_data`=0, `byte_valid`=0, `busy`=0, `done`=0; all counters 0.
- All outputs are registered or decoded from state only; no combinational path from `byte_ready` to `byte_valid`.
- `start` accepted at edge 0:
  - READ in cycle 1 (`mem_rd_en`).
  - WAIT in cycle 2.
  - First `byte_valid` in cycle 3.
- With `byte_ready` held high, each word takes 11 cycles (READ + WAIT + 9 bytes).
- N-word dump: `done` in cycle 11·N+1 after `start`.
- `word_count`=0: `done` in cycle 1, no memory reads.
- `busy` drops the cycle after `done`.
- A new `start` is accepted in that same cycle.

## Structure
- Shared package `dump_pkg`:
  - state enum (IDLE, READ, WAIT, SEND, FIN);
  - constants ASCII_0=0x30, ASCII_A_OFS=0x57, ASCII_LF=0x0A, CHARS_PER_WORD=9.
- One combinational sub-module, `nibble_ascii` (4-bit in, 8-bit ASCII out), instantiated once on the selected nibble.
- The FSM, counters and word register live in `dmem_hex_dump`.

## Test plan
- Single word: mem[0x10]=0x1234abcd; start with base=0x10, count=1, ready=1 → bytes "1234abcd\n" (0x31 0x32 0x33 0x34 0x61 0x62 0x63 0x64 0x0A) in cycles 3-11; `done` in cycle 12; exactly one `mem_rd_en`.
- Three words at base=0x00, values 0, 0xffffffff, 0x0000000a → "00000000\n", "ffffffff\n", "0000000a\n"; reads at 0, 1, 2; 27 bytes total; `done` in cycle 34.
- Backpressure: `byte_ready` random at 30% → identical byte sequence; `byte_data` unchanged across every stalled cycle; no dropped or duplicated bytes.
- Wrap-around: base=0xFE, count=3 → reads at 0xFE, 0xFF, 0x00.
- Zero count and ignored restart:
  - count=0 → `done` in cycle 1, `byte_valid` never asserts.
  - `start` pulsed during SEND → no effect on the stream.
- Reset mid-dump: assert `reset_0` while the 5th character of word 2 is presented → next cycle all outputs at reset values, no `done`; a fresh `start` dumps correctly from the new base.
